// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Types and helpers shared by the weighted round-robin lock arbiter.
//   arb_state_e    : arbiter FSM states (IDLE, LOCKED)
//   MaxReq         : widest one-hot vector onehot_to_idx accepts
//   onehot_to_idx  : binary index of a one-hot vector (0 for all-zero)
// No ports (package).
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned MaxReq      = 32;
  localparam int unsigned MaxIdxWidth = 5;

  // OR-ing indices is exact for a one-hot input and yields 0 for all-zero.
  function automatic logic [MaxIdxWidth-1:0] onehot_to_idx(input logic [MaxReq-1:0] onehot);
    logic [MaxIdxWidth-1:0] idx;
    idx = '0;
    for (int i = 0; i < MaxReq; i++) begin
      if (onehot[i]) begin
        idx = idx | i[MaxIdxWidth-1:0];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: returns the first set req bit at or above
// the one-hot pointer, wrapping from NumReq-1 back to 0.
// Ports:
//   req   [NumReq-1:0]  request vector
//   ptr   [NumReq-1:0]  one-hot priority pointer
//   grant [NumReq-1:0]  one-hot winner, all-zero when req is all-zero
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0] req,
  input  logic [NumReq-1:0] ptr,
  output logic [NumReq-1:0] grant
);

  logic [NumReq-1:0]   upper_mask;
  logic [2*NumReq-1:0] dbl;
  logic [2*NumReq-1:0] lowest;

  // The low half holds only requests at/above ptr, the high half holds all of
  // them; isolating the lowest set bit of the doubled vector gives the wrapped
  // priority winner, folded back onto NumReq bits.
  always_comb begin
    upper_mask = ~(ptr - NumReq'(1));
    dbl        = {req, req & upper_mask};
    lowest     = dbl & ~(dbl - (2*NumReq)'(1));
    grant      = lowest[NumReq-1:0] | lowest[2*NumReq-1:NumReq];
  end

endmodule

// File: rtl/wrr_arbiter_lock.sv
// -----------------------------------------------------------------------------
// wrr_arbiter_lock
// Weighted round-robin arbiter with grant locking. In IDLE the winner is
// granted combinationally and latched; the arbiter then stays LOCKED on that
// requester until unlock_i. A requester of weight W that keeps requesting
// gets W consecutive locks before the pointer moves past it.
// Optional feature (macro WRR_ARB_TIMEOUT_EN): a lock held for MaxHold cycles
// without unlock_i is forcibly released and timeout_o pulses for one cycle.
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   req_i          [NumReq-1:0] request vector
//   weight_i       [NumReq-1:0][WeightWidth-1:0] grants per turn (0 acts as 1)
//   unlock_i       releases the current lock
//   grant_o        [NumReq-1:0] one-hot grant or zero
//   grant_idx_o    [IdxWidth-1:0] binary index of grant_o
//   grant_valid_o  OR of grant_o
//   timeout_o      one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module wrr_arbiter_lock
  import arb_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned WeightWidth = 3,
  parameter int unsigned MaxHold     = 64,
  localparam int unsigned IdxWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0][WeightWidth-1:0]  weight_i,
  input  logic                                unlock_i,
  output logic [NumReq-1:0]                   grant_o,
  output logic [IdxWidth-1:0]                 grant_idx_o,
  output logic                                grant_valid_o,
  output logic                                timeout_o
);

  // Parameter sanity, caught at elaboration.
  if (NumReq < 2 || NumReq > MaxReq || MaxHold < 2) begin : g_param_check
    $error("wrr_arbiter_lock: NumReq must be 2..32 and MaxHold >= 2");
  end

  arb_state_e             state_q, state_d;
  logic [NumReq-1:0]      ptr_q, ptr_d;
  logic [WeightWidth-1:0] cnt_q, cnt_d;
  logic [NumReq-1:0]      grant_q, grant_d;
  logic [NumReq-1:0]      grant_int;
  logic [NumReq-1:0]      pick;
  logic [NumReq-1:0]      pick_next;
  logic [NumReq-1:0]      grant_q_next;
  logic [IdxWidth-1:0]    pick_idx;
  logic [WeightWidth-1:0] w_eff;
  logic [WeightWidth-1:0] new_cnt;
  logic [NumReq-1:0]      new_ptr;

`ifdef WRR_ARB_TIMEOUT_EN
  localparam int unsigned HoldWidth = $clog2(MaxHold);
  logic [HoldWidth-1:0] hold_q, hold_d;
  logic                 timeout_q, timeout_d;
`endif

  rr_pick #(
    .NumReq(NumReq)
  ) u_rr_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .grant (pick)
  );

  // Credit and pointer that a new grant to the current pick would produce.
  // Staying on the same requester spends one credit; landing on a different
  // one reloads its weight. An exhausted credit moves the pointer past it.
  always_comb begin
    pick_next    = {pick[NumReq-2:0], pick[NumReq-1]};
    grant_q_next = {grant_q[NumReq-2:0], grant_q[NumReq-1]};
    pick_idx     = IdxWidth'(onehot_to_idx(MaxReq'(pick)));
    w_eff        = (weight_i[pick_idx] == '0) ? WeightWidth'(1) : weight_i[pick_idx];
    if ((ptr_q == pick) && (cnt_q != '0)) begin
      new_cnt = cnt_q - WeightWidth'(1);
    end else begin
      new_cnt = w_eff - WeightWidth'(1);
    end
    new_ptr = (new_cnt == '0) ? pick_next : pick;
  end

  // Next-state logic: IDLE grants the live pick and locks it; LOCKED replays
  // the latched grant until unlock_i (or the hold limit, when enabled).
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    grant_int = '0;
`ifdef WRR_ARB_TIMEOUT_EN
    hold_d    = '0;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        grant_int = pick;
        if (|req_i) begin
          state_d = LOCKED;
          grant_d = pick;
          cnt_d   = new_cnt;
          ptr_d   = new_ptr;
        end
      end
      LOCKED: begin
        grant_int = grant_q;
        if (unlock_i) begin
          state_d = IDLE;
`ifdef WRR_ARB_TIMEOUT_EN
        end else if (hold_q == HoldWidth'(MaxHold - 1)) begin
          // Forced release forfeits the remaining credit.
          state_d   = IDLE;
          cnt_d     = '0;
          ptr_d     = grant_q_next;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HoldWidth'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= NumReq'(1);
      cnt_q     <= '0;
      grant_q   <= '0;
`ifdef WRR_ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
`ifdef WRR_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Outputs are forced quiet while reset is asserted, even before the edge.
  always_comb begin
    grant_o       = rst_n ? grant_int : '0;
    grant_idx_o   = IdxWidth'(onehot_to_idx(MaxReq'(grant_o)));
    grant_valid_o = |grant_o;
`ifdef WRR_ARB_TIMEOUT_EN
    timeout_o     = rst_n & timeout_q;
`else
    timeout_o     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_wrr_arbiter_lock.sv
// -----------------------------------------------------------------------------
// tb_wrr_arbiter_lock
// Directed self-checking bench for wrr_arbiter_lock (NumReq=4, WeightWidth=3,
// MaxHold=8). Timeout scenarios run when WRR_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_wrr_arbiter_lock;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_i;
  logic [3:0][2:0] weight_i;
  logic            unlock_i;
  logic [3:0]      grant_o;
  logic [1:0]      grant_idx_o;
  logic            grant_valid_o;
  logic            timeout_o;

  int checkCount = 0;
  int passCount  = 0;

  wrr_arbiter_lock #(
    .NumReq      (4),
    .WeightWidth (3),
    .MaxHold     (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .weight_i      (weight_i),
    .unlock_i      (unlock_i),
    .grant_o       (grant_o),
    .grant_idx_o   (grant_idx_o),
    .grant_valid_o (grant_valid_o),
    .timeout_o     (timeout_o)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives all control inputs and lets combinational outputs settle.
  task automatic applyStimulus(input logic rstN, input logic [3:0] req, input logic unlock);
    rst_n    = rstN;
    req_i    = req;
    unlock_i = unlock;
    #1;
  endtask

  // Advance one clock; outputs are sampled 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
  endtask

  // One complete lock: check the zero-latency IDLE grant, lock, check the
  // held grant while pulsing unlock, then return to IDLE.
  task automatic doLock(input string tag, input logic [3:0] expOh, input logic [1:0] expIdx);
    checkOutput({tag, "_idle_grant"}, grant_o, expOh);
    checkOutput({tag, "_idle_idx"}, grant_idx_o, expIdx);
    tick();
    applyStimulus(1'b1, req_i, 1'b1);
    checkOutput({tag, "_lock_grant"}, grant_o, expOh);
    checkOutput({tag, "_lock_valid"}, grant_valid_o, 1'b1);
    tick();
    applyStimulus(1'b1, req_i, 1'b0);
  endtask

  int holdCycles;
  logic [1:0] rrSeq [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] wSeq  [8]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};

  initial begin
    weight_i = {3'd1, 3'd1, 3'd1, 3'd1};
    rst_n    = 1'b0;
    req_i    = '0;
    unlock_i = 1'b0;

    // Outputs quiet during reset even with requests pending.
    applyStimulus(1'b0, 4'b1111, 1'b0);
    tick();
    checkOutput("rst_grant", grant_o, 4'b0000);
    checkOutput("rst_idx", grant_idx_o, 2'd0);
    checkOutput("rst_valid", grant_valid_o, 1'b0);
    checkOutput("rst_timeout", timeout_o, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("noreq_grant", grant_o, 4'b0000);
    checkOutput("noreq_idx", grant_idx_o, 2'd0);
    tick();
    checkOutput("noreq_grant2", grant_o, 4'b0000);

    // Plain round robin with unit weights.
    applyStimulus(1'b1, 4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      doLock($sformatf("rr%0d", k), 4'(1 << rrSeq[k]), rrSeq[k]);
    end

    // Requester 0 has weight 3.
    doReset();
    weight_i = {3'd1, 3'd1, 3'd1, 3'd3};
    applyStimulus(1'b1, 4'b0011, 1'b0);
    for (int k = 0; k < 8; k++) begin
      doLock($sformatf("wrr%0d", k), 4'(1 << wSeq[k]), wSeq[k]);
    end

    // Lock holds after the request drops, until the cycle after unlock.
    doReset();
    weight_i = {3'd1, 3'd1, 3'd1, 3'd1};
    applyStimulus(1'b1, 4'b0100, 1'b0);
    checkOutput("hold_idle_grant", grant_o, 4'b0100);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
`ifdef WRR_ARB_TIMEOUT_EN
    holdCycles = 5;
`else
    holdCycles = 70;
`endif
    for (int k = 0; k < holdCycles; k++) begin
      checkOutput($sformatf("hold_c%0d", k), grant_o, 4'b0100);
      tick();
    end
    checkOutput("hold_timeout", timeout_o, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("hold_unlock_cycle", grant_o, 4'b0100);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("hold_released", grant_o, 4'b0000);
    checkOutput("hold_released_valid", grant_valid_o, 1'b0);
    checkOutput("hold_released_to", timeout_o, 1'b0);

    // Reset while locked drops the lock and restarts the pointer at 0.
    doReset();
    applyStimulus(1'b1, 4'b1000, 1'b0);
    checkOutput("rl_idle_grant", grant_o, 4'b1000);
    tick();
    checkOutput("rl_locked", grant_o, 4'b1000);
    applyStimulus(1'b0, 4'b1000, 1'b0);
    checkOutput("rl_rst_grant", grant_o, 4'b0000);
    checkOutput("rl_rst_idx", grant_idx_o, 2'd0);
    tick();
    applyStimulus(1'b1, 4'b1010, 1'b0);
    checkOutput("rl_after_grant", grant_o, 4'b0010);
    checkOutput("rl_after_idx", grant_idx_o, 2'd1);

    // unlock_i while IDLE does not prevent or shorten a lock.
    doReset();
    applyStimulus(1'b1, 4'b0010, 1'b1);
    checkOutput("iu_idle_grant", grant_o, 4'b0010);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("iu_locked", grant_o, 4'b0010);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("iu_released", grant_o, 4'b0000);

    // Weight 0 behaves as weight 1.
    doReset();
    weight_i = {3'd0, 3'd0, 3'd0, 3'd0};
    applyStimulus(1'b1, 4'b0011, 1'b0);
    doLock("w0_a", 4'b0001, 2'd0);
    doLock("w0_b", 4'b0010, 2'd1);
    doLock("w0_c", 4'b0001, 2'd0);

`ifdef WRR_ARB_TIMEOUT_EN
    // Forced release after 8 LOCKED cycles, then the next requester wins.
    doReset();
    weight_i = {3'd1, 3'd1, 3'd1, 3'd1};
    applyStimulus(1'b1, 4'b0101, 1'b0);
    checkOutput("to_idle_grant", grant_o, 4'b0001);
    tick();
    for (int k = 0; k < 7; k++) begin
      checkOutput($sformatf("to_lock_c%0d", k), grant_o, 4'b0001);
      checkOutput($sformatf("to_pulse_c%0d", k), timeout_o, 1'b0);
      tick();
    end
    checkOutput("to_last_lock", grant_o, 4'b0001);
    checkOutput("to_last_pulse", timeout_o, 1'b0);
    tick();
    checkOutput("to_pulse", timeout_o, 1'b1);
    checkOutput("to_next_grant", grant_o, 4'b0100);
    tick();
    checkOutput("to_pulse_gone", timeout_o, 1'b0);
    checkOutput("to_relock", grant_o, 4'b0100);

    // unlock_i on the timeout cycle wins: normal release, no pulse.
    for (int k = 0; k < 7; k++) begin
      tick();
    end
    applyStimulus(1'b1, 4'b0101, 1'b1);
    checkOutput("tu_last_lock", grant_o, 4'b0100);
    tick();
    applyStimulus(1'b1, 4'b0101, 1'b0);
    checkOutput("tu_no_pulse", timeout_o, 1'b0);
    checkOutput("tu_next_grant", grant_o, 4'b0001);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter_lock.md
WRR_ARBITER_LOCK -- requirements
Module: wrr_arbiter_lock

Interface
REQ-001 Parameter NumReq, default 4, number of requesters (>=2).
REQ-002 Parameter WeightWidth, default 3, width of each per-requester weight.
REQ-003 Parameter MaxHold, default 64, lock-timeout cycle count (>=2; used only with the timeout feature).
REQ-004 Localparam IdxWidth = max(1, clog2(NumReq)).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req_i  input  NumReq  request vector, bit i = requester i.
REQ-008 weight_i  input  NumReq x WeightWidth  grants per turn; 0 treated as 1.
REQ-009 unlock_i  input  1  releases the current lock.
REQ-010 grant_o  output  NumReq  one-hot grant, or all-zero.
REQ-011 grant_idx_o  output  IdxWidth  binary index of grant_o; 0 when no grant.
REQ-012 grant_valid_o  output  1  OR-reduction of grant_o.
REQ-013 timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-014 FSM states: IDLE, LOCKED.
REQ-015 IDLE: grant_o = combinational pick (zero latency), first set req_i bit at or above ptr, wrapping from NumReq-1 to 0.
REQ-016 IDLE with any req_i set: next state LOCKED; winner g latched into grant register.
REQ-017 LOCKED: grant_o = latched grant, independent of req_i (requester may drop req_i).
REQ-018 LOCKED with unlock_i=1: next state IDLE; new arbitration starts the cycle after.
REQ-019 unlock_i in IDLE is ignored.
REQ-020 Credit on each new grant to g, with w(g) = max(weight_i[g],1) sampled that cycle: if ptr == onehot(g) and cnt != 0, then cnt <= cnt-1; otherwise cnt <= w(g)-1.
REQ-021 Pointer update: if the new cnt == 0, ptr <= onehot((g+1) mod NumReq); otherwise ptr <= onehot(g).
REQ-022 A requester with weight W that keeps requesting receives W consecutive locks before the pointer passes it.
REQ-023 cnt width is WeightWidth; arithmetic never underflows.

Reset
REQ-024 While rst_n=0 at a clock edge: state=IDLE, ptr=onehot(0), cnt=0, grant register=0, hold counter=0.
REQ-025 grant_o, grant_idx_o, grant_valid_o and timeout_o SHALL read 0 while rst_n=0.
REQ-026 Reset asserted while LOCKED drops the lock in the same edge.

Configuration
REQ-027 Macro WRR_ARB_TIMEOUT_EN defined: a hold counter counts cycles in LOCKED; at count MaxHold-1 without unlock_i, the next edge forces IDLE, timeout_o pulses one cycle, cnt <= 0, ptr <= onehot(g+1).
REQ-028 If unlock_i and timeout coincide, unlock_i wins and timeout_o stays 0.
REQ-029 Macro WRR_ARB_TIMEOUT_EN undefined: no hold counter; timeout_o tied 0; the lock is released only by unlock_i.

Structure
REQ-030 Shared package arb_pkg holds arb_state_e (IDLE, LOCKED) and a onehot-to-binary function.
REQ-031 One sub-module, rr_pick: combinational double-width masked priority pick (req, ptr -> one-hot grant).

Verification
REQ-032 Reset, req_i=0000 -> grant_o=0000, grant_idx_o=0; then req_i=1111, all weights=1, unlock_i pulsed per lock -> grants 0001, 0010, 0100, 1000, 0001.
REQ-033 weight_i={1,1,1,3} (req0 weight 3), req_i=0011 held, unlock per lock -> grant sequence 0,0,0,1,0,0,0,1.
REQ-034 Lock to req2, req_i drops to 0000 -> grant_o stays 0100 until the cycle after unlock_i, then 0000.
REQ-035 With WRR_ARB_TIMEOUT_EN and MaxHold=8, no unlock -> release after 8 LOCKED cycles, timeout_o=1 for one cycle, next grant goes to the next requester.
REQ-036 rst_n=0 while LOCKED on req3 -> next cycle IDLE, ptr=0, req_i=1010 -> grant 0010.
REQ-037 unlock_i in the same cycle as the timeout -> timeout_o=0, normal release.
